// File: rtl/led_display_pkg.sv
// Shared types and helpers for the LED panel display path.
package led_display_pkg;

    localparam int ROW_BITS = 64;

    typedef struct packed {
        logic [ROW_BITS-1:0] r0;
        logic [ROW_BITS-1:0] g0;
        logic [ROW_BITS-1:0] b0;
        logic [ROW_BITS-1:0] r1;
        logic [ROW_BITS-1:0] g1;
        logic [ROW_BITS-1:0] b1;
    } rgb_row_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } row_drv_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/led_display_bclk_div.sv
// Phase counter for the panel shift clock: one-cycle tick every HALF cycles.
module led_display_bclk_div #(
    parameter int HALF = 3
) (
    input  logic clk_in,
    input  logic n_reset_in,
    input  logic enable,
    output logic tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] phase;

    assign tick = enable && (phase == CW'(HALF - 1));

    // Held at zero while disabled so every phase starts a full HALF period.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            phase <= '0;
        end else if (!enable || tick) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: shifts one dual-scan row out, latches it, then displays it.
module led_display_row_driver
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int BCLK_FREQ      = 21_000_000,
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = ROW_BITS,
    parameter int DISPLAY_CYCLES = 1024,
    localparam int ADDR_W        = $clog2(NUM_ROW_PIXELS / 2)
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  rgb_row_t          row_in,
    input  logic              row_valid_in,
    output logic              row_ready_out,
    input  logic [ADDR_W-1:0] row_address_in,
    output logic              bclk_out,
    output logic              r0_out,
    output logic              g0_out,
    output logic              b0_out,
    output logic              r1_out,
    output logic              g1_out,
    output logic              b1_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              latch_out,
    output logic              n_oe_out
);

    localparam int HALF_RAW = ceil_div(SYS_CLK_FREQ, 2 * BCLK_FREQ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int COL_W    = (NUM_COL_PIXELS > 1) ? $clog2(NUM_COL_PIXELS) : 1;
    localparam int DISP_W   = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;

    row_drv_state_t    state;
    row_drv_state_t    state_n;
    rgb_row_t          sr;
    logic [ADDR_W-1:0] addr_q;
    logic [COL_W-1:0]  col;
    logic [DISP_W-1:0] disp;
    logic              tick;
    logic              take;
    logic              last_col;
    logic              div_en;

    assign take     = row_valid_in && row_ready_out;
    assign last_col = (col == COL_W'(NUM_COL_PIXELS - 1));
    assign div_en   = (state == SHIFT) || (state == LATCH);

    led_display_bclk_div #(
        .HALF(HALF)
    ) u_bclk_div (
        .clk_in    (clk_in),
        .n_reset_in(n_reset_in),
        .enable    (div_en),
        .tick      (tick)
    );

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (take) state_n = SHIFT;
            SHIFT:   if (tick && bclk_out && last_col) state_n = BLANK;
            BLANK:   state_n = LATCH;
            LATCH:   if (tick) state_n = DISPLAY;
            DISPLAY: if (disp == DISP_W'(DISPLAY_CYCLES - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs follow the next state so they are registered yet aligned.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            sr            <= '0;
            addr_q        <= '0;
            col           <= '0;
            disp          <= '0;
            row_ready_out <= 1'b1;
            bclk_out      <= 1'b0;
            r0_out        <= 1'b0;
            g0_out        <= 1'b0;
            b0_out        <= 1'b0;
            r1_out        <= 1'b0;
            g1_out        <= 1'b0;
            b1_out        <= 1'b0;
            addr_out      <= '0;
            latch_out     <= 1'b0;
            n_oe_out      <= 1'b1;
        end else begin
            row_ready_out <= (state_n == IDLE);
            latch_out     <= (state_n == LATCH);
            n_oe_out      <= (state_n != DISPLAY);
            disp          <= (state == DISPLAY) ? disp + 1'b1 : '0;
            if (take) begin
                sr       <= row_in;
                addr_q   <= row_address_in;
                col      <= '0;
                bclk_out <= 1'b0;
                r0_out   <= row_in.r0[0];
                g0_out   <= row_in.g0[0];
                b0_out   <= row_in.b0[0];
                r1_out   <= row_in.r1[0];
                g1_out   <= row_in.g1[0];
                b1_out   <= row_in.b1[0];
            end else if (state == SHIFT && tick) begin
                bclk_out <= ~bclk_out;
                // Falling edge of BCLK: move to next column or finish the row.
                if (bclk_out) begin
                    if (last_col) begin
                        r0_out   <= 1'b0;
                        g0_out   <= 1'b0;
                        b0_out   <= 1'b0;
                        r1_out   <= 1'b0;
                        g1_out   <= 1'b0;
                        b1_out   <= 1'b0;
                        addr_out <= addr_q;
                    end else begin
                        col    <= col + 1'b1;
                        sr.r0  <= sr.r0 >> 1;
                        sr.g0  <= sr.g0 >> 1;
                        sr.b0  <= sr.b0 >> 1;
                        sr.r1  <= sr.r1 >> 1;
                        sr.g1  <= sr.g1 >> 1;
                        sr.b1  <= sr.b1 >> 1;
                        r0_out <= sr.r0[1];
                        g0_out <= sr.g0[1];
                        b0_out <= sr.b0[1];
                        r1_out <= sr.r1[1];
                        g1_out <= sr.g1[1];
                        b1_out <= sr.b1[1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_display_row_driver.sv
// Directed bench for led_display_row_driver: serial stream, latch/OE timing,
// handshake, reset and a fast-BCLK short-display instance.
module tb_led_display_row_driver;
    import led_display_pkg::*;

    typedef struct packed {
        logic       bclk;
        logic       r0;
        logic       g0;
        logic       b0;
        logic       r1;
        logic       g1;
        logic       b1;
        logic       latch;
        logic       noe;
        logic       ready;
        logic [3:0] addr;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rgb_row_t   row_a, row_b;
    logic       va, vb;
    logic [3:0] aa, ab;
    logic       rdy_a, bclk_a, r0_a, g0_a, b0_a, r1_a, g1_a, b1_a, latch_a, noe_a;
    logic       rdy_b, bclk_b, r0_b, g0_b, b0_b, r1_b, g1_b, b1_b, latch_b, noe_b;
    logic [3:0] addr_a, addr_b;

    led_display_row_driver dut_a (
        .clk_in(clk), .n_reset_in(rst_n),
        .row_in(row_a), .row_valid_in(va), .row_ready_out(rdy_a),
        .row_address_in(aa), .bclk_out(bclk_a),
        .r0_out(r0_a), .g0_out(g0_a), .b0_out(b0_a),
        .r1_out(r1_a), .g1_out(g1_a), .b1_out(b1_a),
        .addr_out(addr_a), .latch_out(latch_a), .n_oe_out(noe_a)
    );

    led_display_row_driver #(
        .BCLK_FREQ(50_000_000), .DISPLAY_CYCLES(16)
    ) dut_b (
        .clk_in(clk), .n_reset_in(rst_n),
        .row_in(row_b), .row_valid_in(vb), .row_ready_out(rdy_b),
        .row_address_in(ab), .bclk_out(bclk_b),
        .r0_out(r0_b), .g0_out(g0_b), .b0_out(b0_b),
        .r1_out(r1_b), .g1_out(g1_b), .b1_out(b1_b),
        .addr_out(addr_b), .latch_out(latch_b), .n_oe_out(noe_b)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    smp_t cap [0:1412];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic smp_t grab(input bit b);
        smp_t s;
        if (b) s = {bclk_b, r0_b, g0_b, b0_b, r1_b, g1_b, b1_b,
                    latch_b, noe_b, rdy_b, addr_b};
        else   s = {bclk_a, r0_a, g0_a, b0_a, r1_a, g1_a, b1_a,
                    latch_a, noe_a, rdy_a, addr_a};
        return s;
    endfunction

    task automatic wait_ready(input bit b);
        int k = 0;
        while (!(b ? rdy_b : rdy_a) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", b ? rdy_b : rdy_a, 1);
    endtask

    task automatic capture(input int n, input bit b, input bit hold,
                           input bit disturb);
        logic [383:0] junk;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap[k] = grab(b);
            if (k == 0 && !hold) begin
                if (b) vb = 1'b0;
                else   va = 1'b0;
            end
            if (disturb && k < 380) begin
                for (int j = 0; j < 12; j++) junk[j*32 +: 32] = $urandom();
                row_a = junk;
                aa    = 4'($urandom());
                va    = ~va;
            end else if (disturb && k == 380) begin
                va = 1'b0;
            end
        end
    endtask

    task automatic analyse(input string t, input rgb_row_t row,
                           input logic [3:0] a, input int h, input int d);
        int n = 128 * h + 2 + h + d;
        int rises = 0, gaps = 0, first = -1, last = -1;
        int lcnt = 0, lfirst = -1, ocnt = 0, ofirst = -1;
        int rhi = 0, moves = 0, dirty = 0;
        logic [3:0] a_pre, a_lat;
        rgb_row_t got = '0;
        for (int k = 0; k < n; k++) begin
            if (cap[k].bclk && (k == 0 || !cap[k-1].bclk)) begin
                if (rises < 64) begin
                    got.r0[rises] = cap[k].r0;
                    got.g0[rises] = cap[k].g0;
                    got.b0[rises] = cap[k].b0;
                    got.r1[rises] = cap[k].r1;
                    got.g1[rises] = cap[k].g1;
                    got.b1[rises] = cap[k].b1;
                end
                if (first < 0) first = k;
                else if (k - last != 2 * h) gaps++;
                last = k;
                rises++;
            end
            if (cap[k].latch) begin
                lcnt++;
                if (lfirst < 0) lfirst = k;
                if ({cap[k].r0, cap[k].g0, cap[k].b0, cap[k].r1,
                     cap[k].g1, cap[k].b1, cap[k].bclk} != 7'd0) dirty++;
            end
            if (!cap[k].noe) begin
                ocnt++;
                if (ofirst < 0) ofirst = k;
                if (k > 0 && cap[k].addr != cap[k-1].addr) moves++;
            end
            if (k < n - 1 && cap[k].ready) rhi++;
        end
        a_pre = (lfirst > 0) ? cap[lfirst-1].addr : 4'hx;
        a_lat = (lfirst >= 0) ? cap[lfirst].addr : 4'hx;
        check({t, ".rises"}, rises, 64);
        check({t, ".gaps"}, gaps, 0);
        check({t, ".first_rise"}, first, h);
        check({t, ".r0"}, got.r0, row.r0);
        check({t, ".g0"}, got.g0, row.g0);
        check({t, ".b0"}, got.b0, row.b0);
        check({t, ".r1"}, got.r1, row.r1);
        check({t, ".g1"}, got.g1, row.g1);
        check({t, ".b1"}, got.b1, row.b1);
        check({t, ".latch_len"}, lcnt, h);
        check({t, ".latch_at"}, lfirst, 128 * h + 1);
        check({t, ".latch_dirty"}, dirty, 0);
        check({t, ".addr_pre"}, a_pre, a);
        check({t, ".addr_latch"}, a_lat, a);
        check({t, ".oe_len"}, ocnt, d);
        check({t, ".oe_at"}, ofirst, 128 * h + 1 + h);
        check({t, ".addr_moves"}, moves, 0);
        check({t, ".ready_busy"}, rhi, 0);
        check({t, ".ready_end"}, cap[n-1].ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rgb_row_t    exp;
        logic [3:0]  b2b [3];
        int          lat, nrdy;
        b2b = '{4'd14, 4'd15, 4'd0};
        va = 1'b0; vb = 1'b0; aa = '0; ab = '0;
        row_a = '0; row_b = '0;

        repeat (3) @(negedge clk);
        check("rst.ready", rdy_a, 1);
        check("rst.noe", noe_a, 1);
        check("rst.bclk", bclk_a, 0);
        check("rst.latch", latch_a, 0);
        check("rst.addr", addr_a, 0);
        check("rst.colours", {r0_a, g0_a, b0_a, r1_a, g1_a, b1_a}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        exp = '0; exp.r0 = 64'h1;
        row_a = exp; aa = 4'd5;
        wait_ready(0); va = 1'b1;
        capture(1413, 0, 0, 0);
        analyse("single", exp, 4'd5, 3, 1024);

        exp = '0;
        exp.g1 = 64'h8000_0000_0000_0000;
        exp.b0 = 64'hAAAA_AAAA_AAAA_AAAA;
        row_a = exp; aa = 4'd10;
        wait_ready(0); va = 1'b1;
        capture(1413, 0, 0, 0);
        analyse("order", exp, 4'd10, 3, 1024);

        wait_ready(0);
        for (int i = 0; i < 3; i++) begin
            exp = '0;
            exp.r0 = 64'h1234_5678_9ABC_DEF0 ^ 64'(i);
            exp.g0 = 64'hFFFF_0000_FFFF_0000 >> i;
            exp.b1 = 64'h0000_0001_8000_0000 << i;
            exp.r1 = 64'hC3C3_3C3C_5A5A_A5A5;
            row_a = exp; aa = b2b[i]; va = 1'b1;
            capture(1413, 0, (i < 2), 0);
            analyse($sformatf("b2b%0d", i), exp, b2b[i], 3, 1024);
        end

        exp = '0;
        exp.r1 = 64'h0F0F_0F0F_0F0F_0F0F;
        exp.b1 = 64'hFFFF_0000_1234_0001;
        row_a = exp; aa = 4'd3;
        wait_ready(0); va = 1'b1;
        capture(1413, 0, 0, 1);
        analyse("busy", exp, 4'd3, 3, 1024);

        exp = '0; exp.r0 = '1;
        row_a = exp; aa = 4'd9;
        wait_ready(0); va = 1'b1;
        capture(100, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst.ready", rdy_a, 1);
        check("midrst.noe", noe_a, 1);
        check("midrst.bclk", bclk_a, 0);
        check("midrst.latch", latch_a, 0);
        check("midrst.addr", addr_a, 0);
        check("midrst.colours", {r0_a, g0_a, b0_a, r1_a, g1_a, b1_a}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lat = 0; nrdy = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (latch_a) lat++;
            if (!rdy_a) nrdy++;
        end
        check("midrst.no_latch", lat, 0);
        check("midrst.idle", nrdy, 0);

        exp = '0;
        exp.r0 = 64'h8000_0000_0000_0001;
        exp.g0 = 64'h0123_4567_89AB_CDEF;
        row_b = exp; ab = 4'd7;
        wait_ready(1); vb = 1'b1;
        capture(147, 1, 1, 0);
        analyse("fast0", exp, 4'd7, 1, 16);
        exp = '0;
        exp.b1 = 64'hDEAD_BEEF_0000_FFFF;
        row_b = exp; ab = 4'd8;
        capture(147, 1, 0, 0);
        analyse("fast1", exp, 4'd8, 1, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_display_row_driver.md
Name: led_display_row_driver

Overview:
- Downstream consumer of led_display_pattern_gen.
- Accepts one dual-scan row (top and bottom half-rows) plus its row address over a valid/ready handshake.
- Serialises the row onto the HUB75 panel pins with a generated BCLK, then blanks, sets the address and pulses latch.
- Enables the outputs for a fixed display time, then returns to accept the next row.

Parameters:
SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz
BCLK_FREQ, 21_000_000, maximum panel shift clock frequency in Hz
NUM_ROW_PIXELS, 32, panel rows; address width ADDR_W = clog2(NUM_ROW_PIXELS/2) = 4
NUM_COL_PIXELS, 64, pixels per row
DISPLAY_CYCLES, 1024, system cycles n_oe_out is held low per row

Ports:
clk_in  input  1  system clock
n_reset_in  input  1  asynchronous active-low reset
row_in  input  rgb_row_t  row data: r0,g0,b0 (top), r1,g1,b1 (bottom), each NUM_COL_PIXELS bits
row_valid_in  input  1  row_in / row_address_in valid
row_ready_out  output  1  block can accept a row
row_address_in  input  ADDR_W  address of row_in
bclk_out  output  1  panel shift clock
r0_out, g0_out, b0_out, r1_out, g1_out, b1_out  output  1 each  serial colour data
addr_out  output  ADDR_W  panel row address
latch_out  output  1  panel latch, active high
n_oe_out  output  1  panel output enable, active low

Behaviour:
- Clock and reset: single clock domain; all registers reset asynchronously on n_reset_in low.
- Reset values: state IDLE, row_ready_out=1, bclk_out=0, all colour outputs 0, addr_out=0, latch_out=0, n_oe_out=1.
- Reset mid-operation: abandon the row immediately and return to reset values; no latch pulse is produced.
- Half period: HALF = ceil(SYS_CLK_FREQ / (2*BCLK_FREQ)), minimum 1. Defaults give HALF=3, so BCLK = 16.67 MHz and never exceeds BCLK_FREQ.
- Outputs: all outputs are registered.
- Handshake: transfer occurs on a rising edge with row_valid_in & row_ready_out. row_ready_out is 1 only in IDLE. row_valid_in outside IDLE is ignored. row_in and row_address_in are sampled only on the transfer edge; later changes have no effect.
- States:
  - IDLE: n_oe_out=1. On transfer, load six shift registers and the address register, clear the column counter, go to SHIFT.
  - SHIFT: for each column c = 0..NUM_COL_PIXELS-1:
    - Low phase, HALF cycles, bclk_out=0: colour outputs present bit c of each field (bit 0 first).
    - High phase, HALF cycles, bclk_out=1: data held stable.
    - Total NUM_COL_PIXELS*2*HALF cycles (384 at defaults).
    - After the last high phase, bclk_out=0; go to BLANK.
  - BLANK: 1 cycle. n_oe_out=1; addr_out <= captured address.
  - LATCH: HALF cycles with latch_out=1; colour outputs and bclk_out at 0.
  - DISPLAY: DISPLAY_CYCLES cycles with n_oe_out=0, then go to IDLE (n_oe_out=1 again).
- Latency at defaults: with transfer on edge e0:
  - latch_out is high after edges e385..e387.
  - n_oe_out is low after edges e388..e1411.
  - row_ready_out returns to 1 after edge e1412.
  - Back-to-back row period with row_valid_in held high = 1413 cycles.
- addr_out changes only in BLANK, never while n_oe_out=0. Any address 0..2^ADDR_W-1 is accepted; wrap 15 -> 0 needs no special handling.
- Counters: the column counter is clog2(NUM_COL_PIXELS) bits and terminates at NUM_COL_PIXELS-1 (no wrap overflow). The phase counter counts 0..HALF-1; the display counter is sized for DISPLAY_CYCLES.

Decomposition:
- led_display_package:
  - rgb_row_t struct with six NUM_COL_PIXELS-bit fields
  - enum row_drv_state_t {IDLE, SHIFT, BLANK, LATCH, DISPLAY}
  - ceil-divide helper function
- Sub-module led_display_bclk_div: enable-gated phase counter emitting a one-cycle tick every HALF cycles; restarts at phase 0 when enabled.

Test Plan:
- Reset: hold n_reset_in low -> row_ready_out=1, n_oe_out=1, bclk_out=0, latch_out=0, addr_out=0; assert mid-SHIFT -> same values within the reset assertion, no latch pulse.
- Single row: r0 = 64'h1, all other fields 0, address 5 -> exactly 64 bclk_out rising edges, each 6 cycles apart; r0_out=1 only around edge 1; one 3-cycle latch pulse; addr_out=5 before latch_out; n_oe_out low for 1024 cycles.
- Bit order and fields: g1 = 64'h8000_0000_0000_0000, b0 = 64'hAAAA_AAAA_AAAA_AAAA -> g1_out=1 only at the 64th rising edge; b0_out alternates 0,1 starting 0; other outputs 0.
- Back-to-back: row_valid_in held high with addresses 14, 15, 0 -> transfers 1413 cycles apart; addr_out sequence 14, 15, 0; addr_out stable whenever n_oe_out=0.
- Busy-ignore: while in SHIFT, change row_in and toggle row_valid_in every cycle -> no transfer and no change to the serial stream; row_ready_out stays 0 until IDLE.
- Parameter check: BCLK_FREQ=50_000_000 -> HALF=1, 128-cycle SHIFT, full row period at DISPLAY_CYCLES=16 = 1+128+1+1+16 = 147 cycles between back-to-back transfers.
